dram_resp_encoder: RTL and testbench
====================================

Name: dram_resp_encoder

Overview:
Return-path block from the DRAM bank controllers back to the L2.
- Accepts completed accesses tagged with bank, row and column IDs.
- Rebuilds the flat L2 address as {bank_id, row_id, col_id}, the inverse of the request-side bank/row/col split.
- Buffers completions in a small in-order FIFO.
- Presents them to the L2 over a valid/ready handshake, absorbing L2 back-pressure.

Parameters:
- ADDR_WIDTH, 13: width of the reconstructed L2 address.
- NUM_OF_BANKS, 8: bank count; bank field is $clog2(NUM_OF_BANKS) bits (address MSBs).
- NUM_OF_ROWS, 128: row count; row field is $clog2(NUM_OF_ROWS) bits (middle field).
- NUM_OF_COLS, 8: column count; column field is $clog2(NUM_OF_COLS) bits (address LSBs).
- DATA_WIDTH, 32: completion data width.
- FIFO_DEPTH, 4: response buffer entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmpl_valid  in  1  bank side presents a completion.
- cmpl_ready  out  1  block can accept a completion.
- cmpl_bank_id  in  $clog2(NUM_OF_BANKS)  completing bank.
- cmpl_row_id  in  $clog2(NUM_OF_ROWS)  completing row.
- cmpl_col_id  in  $clog2(NUM_OF_COLS)  completing column.
- cmpl_is_write  in  1  1 = write ack, 0 = read data.
- cmpl_data  in  DATA_WIDTH  read data (don't-care for writes).
- l2_resp_valid  out  1  response available to L2.
- l2_resp_ready  in  1  L2 accepts response.
- l2_resp_address  out  ADDR_WIDTH  reconstructed address.
- l2_resp_is_write  out  1  copy of cmpl_is_write.
- l2_resp_data  out  DATA_WIDTH  read data; forced to 0 for write acks.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries.

Behaviour:
- Elaboration: ADDR_WIDTH must equal the sum of the three $clog2 field widths, otherwise $fatal.
- Address encoding is a pure concatenation, no arithmetic: l2_resp_address = {bank, row, col}. With defaults this is bank in [12:10], row in [9:3], col in [2:0].
- Push: occurs when cmpl_valid and cmpl_ready are both 1 on a rising edge.
  - Encoding happens at push time; the FIFO stores address, is_write and data.
- cmpl_ready = (fifo_count != FIFO_DEPTH).
  - Registered-state derived only; no combinational path from l2_resp_ready.
  - A full FIFO therefore refuses input even when the L2 pops in the same cycle.
- Pop: occurs when l2_resp_valid and l2_resp_ready are both 1 on a rising edge.
- l2_resp_valid = (fifo_count != 0). The l2_resp_* outputs are the head entry, driven straight from storage.
- Latency: a completion pushed at edge N is visible on l2_resp_valid after edge N (next cycle). There is no same-cycle bypass.
- Handshake rule: once l2_resp_valid is 1, it and all l2_resp_* outputs stay stable until a pop.
- Ordering: strict FIFO order; no reordering across banks.
- Simultaneous push and pop (FIFO neither empty nor full): count unchanged, both pointers advance.
- Empty: a pop attempt is impossible since valid is 0. Full: cmpl_ready is 0 and the count holds.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH; fifo_count tracks occupancy in 0..FIFO_DEPTH.
- Reset (asynchronous assert, any time, including mid-transfer):
  - Immediately: pointers = 0, fifo_count = 0, l2_resp_valid = 0, cmpl_ready = 1, l2_resp_address = 0, l2_resp_data = 0, l2_resp_is_write = 0.
  - All buffered entries are discarded.
  - Release is synchronous to clk; the first push is allowed on the first edge after release.

Test Plan:
- Single read: bank=5, row=0x2A, col=3, data=0xDEADBEEF, l2_resp_ready=1 -> next cycle l2_resp_valid=1, address=0x1553, data=0xDEADBEEF, is_write=0; fifo_count returns to 0 after the pop.
- Field extremes: push (0,0,0) then (7,127,7) as write acks -> addresses 0x0000 then 0x1FFF in order, l2_resp_data=0, is_write=1.
- Back-pressure fill: l2_resp_ready=0, offer 5 completions on back-to-back cycles.
  - Expect fifo_count 1,2,3,4; cmpl_ready=0 after the 4th push; the 5th is held.
  - l2_resp_* stays at entry 0 throughout.
  - Raising ready drains entries 0..3 in order, then the 5th is accepted.
- Streaming: cmpl_valid=1 and l2_resp_ready=1 every cycle for 16 sequential addresses 0x000..0x00F -> fifo_count settles at 1, one response per cycle in order; pointers wrap with no loss or duplication.
- Full plus simultaneous pop: FIFO at 4 with ready=1 and cmpl_valid=1 -> the pop occurs, the push is refused that cycle (cmpl_ready=0), fifo_count=3; the push is accepted on the next edge.
- Reset mid-operation: with 3 entries buffered, pulse rst_n low between edges -> valid drops to 0 and count to 0 asynchronously, cmpl_ready=1; after release a new push of (1,0,0) returns address 0x0400 as the first response.

Source files
------------

// File: rtl/dram_resp_if.sv
// Bank-side completion channel and L2-side response channel of the DRAM return path.
// The slave modport is the encoder; the master modport is whatever drives it.
interface dram_resp_if #(
    parameter int ADDR_WIDTH   = 13,
    parameter int NUM_OF_BANKS = 8,
    parameter int NUM_OF_ROWS  = 128,
    parameter int NUM_OF_COLS  = 8,
    parameter int DATA_WIDTH   = 32
);
    localparam int BANK_W = $clog2(NUM_OF_BANKS);
    localparam int ROW_W  = $clog2(NUM_OF_ROWS);
    localparam int COL_W  = $clog2(NUM_OF_COLS);

    logic                  cmpl_valid;
    logic                  cmpl_ready;
    logic [BANK_W-1:0]     cmpl_bank_id;
    logic [ROW_W-1:0]      cmpl_row_id;
    logic [COL_W-1:0]      cmpl_col_id;
    logic                  cmpl_is_write;
    logic [DATA_WIDTH-1:0] cmpl_data;

    logic                  l2_resp_valid;
    logic                  l2_resp_ready;
    logic [ADDR_WIDTH-1:0] l2_resp_address;
    logic                  l2_resp_is_write;
    logic [DATA_WIDTH-1:0] l2_resp_data;

    modport master (
        output cmpl_valid, cmpl_bank_id, cmpl_row_id, cmpl_col_id, cmpl_is_write, cmpl_data,
        input  cmpl_ready,
        input  l2_resp_valid, l2_resp_address, l2_resp_is_write, l2_resp_data,
        output l2_resp_ready
    );

    modport slave (
        input  cmpl_valid, cmpl_bank_id, cmpl_row_id, cmpl_col_id, cmpl_is_write, cmpl_data,
        output cmpl_ready,
        output l2_resp_valid, l2_resp_address, l2_resp_is_write, l2_resp_data,
        input  l2_resp_ready
    );
endinterface

// File: rtl/dram_resp_encoder.sv
// Rebuilds {bank,row,col} L2 addresses for DRAM completions and returns them to the L2
// in arrival order through a small FIFO that absorbs L2 back-pressure.
module dram_resp_encoder #(
    parameter int ADDR_WIDTH   = 13,
    parameter int NUM_OF_BANKS = 8,
    parameter int NUM_OF_ROWS  = 128,
    parameter int NUM_OF_COLS  = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    dram_resp_if.slave                    bus,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int BANK_W = $clog2(NUM_OF_BANKS);
    localparam int ROW_W  = $clog2(NUM_OF_ROWS);
    localparam int COL_W  = $clog2(NUM_OF_COLS);
    localparam int PW     = $clog2(FIFO_DEPTH);
    localparam int CW     = PW + 1;

    if (ADDR_WIDTH != BANK_W + ROW_W + COL_W) begin : g_bad_addr_width
        $fatal(1, "dram_resp_encoder: ADDR_WIDTH must equal bank+row+col field widths");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "dram_resp_encoder: FIFO_DEPTH must be a power of 2 and at least 2");
    end

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  is_write;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t          mem [FIFO_DEPTH];
    entry_t          wr_entry;
    entry_t          head;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            push;
    logic            pop;
    logic            not_empty;

    // Ready depends only on occupancy, so a full FIFO refuses input even on a pop cycle.
    assign bus.cmpl_ready = (fifo_count != CW'(FIFO_DEPTH));
    assign not_empty      = (fifo_count != '0);
    assign push           = bus.cmpl_valid & bus.cmpl_ready;
    assign pop            = not_empty & bus.l2_resp_ready;

    always_comb begin
        wr_entry          = '0;
        wr_entry.addr     = {bus.cmpl_bank_id, bus.cmpl_row_id, bus.cmpl_col_id};
        wr_entry.is_write = bus.cmpl_is_write;
        wr_entry.data     = bus.cmpl_is_write ? '0 : bus.cmpl_data;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      fifo_count <= fifo_count + CW'(1);
            else if (pop && !push) fifo_count <= fifo_count - CW'(1);
        end
    end

    // Storage is not reset; masking with occupancy gives zeroed outputs while empty or in reset.
    assign head                 = mem[rd_ptr];
    assign bus.l2_resp_valid    = not_empty;
    assign bus.l2_resp_address  = not_empty ? head.addr : '0;
    assign bus.l2_resp_is_write = not_empty ? head.is_write : 1'b0;
    assign bus.l2_resp_data     = not_empty ? head.data : '0;
endmodule

// File: tb/tb_dram_resp_encoder.sv
// Bench for dram_resp_encoder: directed scenarios plus random traffic against a queue model.
module tb_dram_resp_encoder;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic [2:0] fifo_count;

    dram_resp_if #(.ADDR_WIDTH(13), .NUM_OF_BANKS(8), .NUM_OF_ROWS(128),
                   .NUM_OF_COLS(8), .DATA_WIDTH(32)) bus ();

    dram_resp_encoder #(.ADDR_WIDTH(13), .NUM_OF_BANKS(8), .NUM_OF_ROWS(128),
                        .NUM_OF_COLS(8), .DATA_WIDTH(32), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of expected responses.
    typedef struct {
        int unsigned addr;
        bit          wr;
        logic [31:0] data;
    } exp_t;
    exp_t model_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_q.delete();
        end else begin
            bit   do_push;
            bit   do_pop;
            exp_t e;
            do_push = (bus.cmpl_valid === 1'b1) && (model_q.size() < DEPTH);
            do_pop  = (bus.l2_resp_ready === 1'b1) && (model_q.size() > 0);
            e.addr  = int'(bus.cmpl_bank_id) * 128 * 8 + int'(bus.cmpl_row_id) * 8
                      + int'(bus.cmpl_col_id);
            e.wr    = bus.cmpl_is_write;
            e.data  = bus.cmpl_is_write ? 32'd0 : bus.cmpl_data;
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back(e);
        end
    end

    always @(negedge clk) begin
        check("cmpl_ready", 64'(bus.cmpl_ready), 64'(model_q.size() < DEPTH));
        check("l2_resp_valid", 64'(bus.l2_resp_valid), 64'(model_q.size() > 0));
        check("fifo_count", 64'(fifo_count), 64'(model_q.size()));
        if (model_q.size() > 0) begin
            check("l2_resp_address", 64'(bus.l2_resp_address), 64'(model_q[0].addr));
            check("l2_resp_is_write", 64'(bus.l2_resp_is_write), 64'(model_q[0].wr));
            check("l2_resp_data", 64'(bus.l2_resp_data), 64'(model_q[0].data));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input int bank, input int row, input int col,
                         input bit wr, input logic [31:0] data);
        bus.cmpl_valid    = 1'b1;
        bus.cmpl_bank_id  = 3'(bank);
        bus.cmpl_row_id   = 7'(row);
        bus.cmpl_col_id   = 3'(col);
        bus.cmpl_is_write = wr;
        bus.cmpl_data     = data;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 64'(bus.l2_resp_valid), 64'd0);
        check({tag, "_count"}, 64'(fifo_count), 64'd0);
        check({tag, "_ready"}, 64'(bus.cmpl_ready), 64'd1);
        check({tag, "_address"}, 64'(bus.l2_resp_address), 64'd0);
        check({tag, "_data"}, 64'(bus.l2_resp_data), 64'd0);
        check({tag, "_is_write"}, 64'(bus.l2_resp_is_write), 64'd0);
    endtask

    initial begin
        rst_n = 1'b1;
        bus.cmpl_valid    = 1'b0;
        bus.cmpl_bank_id  = '0;
        bus.cmpl_row_id   = '0;
        bus.cmpl_col_id   = '0;
        bus.cmpl_is_write = 1'b0;
        bus.cmpl_data     = '0;
        bus.l2_resp_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        #10 rst_n = 1'b1;
        step();

        // Single read
        bus.l2_resp_ready = 1'b1;
        offer(5, 'h2A, 3, 1'b0, 32'hDEADBEEF);
        step();
        bus.cmpl_valid = 1'b0;
        check("single_valid", 64'(bus.l2_resp_valid), 64'd1);
        check("single_address", 64'(bus.l2_resp_address), 64'h1553);
        check("single_data", 64'(bus.l2_resp_data), 64'hDEADBEEF);
        check("single_is_write", 64'(bus.l2_resp_is_write), 64'd0);
        step();
        check("single_drained", 64'(fifo_count), 64'd0);

        // Field extremes as write acks
        bus.l2_resp_ready = 1'b0;
        offer(0, 0, 0, 1'b1, 32'h12345678);
        step();
        offer(7, 127, 7, 1'b1, 32'hFFFFFFFF);
        step();
        bus.cmpl_valid = 1'b0;
        check("ext_count", 64'(fifo_count), 64'd2);
        check("ext_addr_lo", 64'(bus.l2_resp_address), 64'h0000);
        check("ext_data_lo", 64'(bus.l2_resp_data), 64'd0);
        check("ext_wr_lo", 64'(bus.l2_resp_is_write), 64'd1);
        bus.l2_resp_ready = 1'b1;
        step();
        check("ext_addr_hi", 64'(bus.l2_resp_address), 64'h1FFF);
        check("ext_data_hi", 64'(bus.l2_resp_data), 64'd0);
        check("ext_wr_hi", 64'(bus.l2_resp_is_write), 64'd1);
        step();
        check("ext_drained", 64'(fifo_count), 64'd0);

        // Back-pressure fill, then full with a simultaneous pop
        bus.l2_resp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            offer(0, 0, i, 1'b0, 32'(100 + i));
            step();
            check("bp_count", 64'(fifo_count), 64'((i < 4) ? i + 1 : 4));
            check("bp_ready", 64'(bus.cmpl_ready), 64'(i < 3));
            check("bp_head", 64'(bus.l2_resp_address), 64'd0);
        end
        bus.l2_resp_ready = 1'b1;
        step();
        check("full_pop_count", 64'(fifo_count), 64'd3);
        check("full_pop_head", 64'(bus.l2_resp_address), 64'd1);
        check("full_pop_ready", 64'(bus.cmpl_ready), 64'd1);
        step();
        bus.cmpl_valid = 1'b0;
        check("late_push_count", 64'(fifo_count), 64'd3);
        check("late_push_head", 64'(bus.l2_resp_address), 64'd2);
        repeat (3) step();
        check("bp_drained", 64'(fifo_count), 64'd0);

        // Streaming 16 sequential addresses
        for (int i = 0; i < 16; i++) begin
            offer(0, i / 8, i % 8, 1'b0, 32'(i * 3 + 1));
            step();
            check("stream_count", 64'(fifo_count), 64'd1);
            check("stream_addr", 64'(bus.l2_resp_address), 64'(i));
        end
        bus.cmpl_valid = 1'b0;
        step();
        check("stream_drained", 64'(fifo_count), 64'd0);

        // Reset with three entries buffered
        bus.l2_resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            offer(2, i, 1, 1'b0, 32'(i));
            step();
        end
        bus.cmpl_valid = 1'b0;
        check("pre_reset_count", 64'(fifo_count), 64'd3);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        #2 rst_n = 1'b1;
        offer(1, 0, 0, 1'b0, 32'hA5A5A5A5);
        step();
        bus.cmpl_valid = 1'b0;
        check("post_reset_addr", 64'(bus.l2_resp_address), 64'h0400);
        check("post_reset_count", 64'(fifo_count), 64'd1);
        bus.l2_resp_ready = 1'b1;
        step();

        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            bus.cmpl_valid    = ($urandom_range(0, 99) < 60);
            bus.cmpl_bank_id  = 3'($urandom_range(0, 7));
            bus.cmpl_row_id   = 7'($urandom_range(0, 127));
            bus.cmpl_col_id   = 3'($urandom_range(0, 7));
            bus.cmpl_is_write = 1'($urandom_range(0, 1));
            bus.cmpl_data     = $urandom;
            bus.l2_resp_ready = ($urandom_range(0, 99) < 50);
            step();
        end
        bus.cmpl_valid    = 1'b0;
        bus.l2_resp_ready = 1'b1;
        repeat (6) step();
        check("final_drained", 64'(fifo_count), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
